// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and requester indices.
package mem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_LSU   = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Parameterised 2:1 multiplexer used to steer the owning requester's payload.
module mux #(
   parameter int WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] dout
);

   assign dout = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port, with a per-transaction
// watchdog that aborts a transaction the memory never acknowledges.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int AWIDTH  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [AWIDTH-1:0] req0_addr,
   input  logic [WIDTH-1:0]  req0_wdata,
   input  logic              req0_we,
   input  logic              req1_valid,
   input  logic [AWIDTH-1:0] req1_addr,
   input  logic [WIDTH-1:0]  req1_wdata,
   input  logic              req1_we,
   output logic              req0_done,
   output logic              req0_err,
   output logic              req1_done,
   output logic              req1_err,
   output logic [WIDTH-1:0]  req_rdata,
   output logic              mem_valid,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              mem_we,
   input  logic              mem_ack,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // The counter holds the number of completed BUSY cycles, so the last allowed cycle sees TIMEOUT-1.
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_t          state_r;
   state_t          state_nxt_s;
   logic            owner_r;
   logic            last_owner_r;
   logic [CW-1:0]   cnt_r;
   logic            grant_s;
   logic            any_req_s;
   logic            ack_s;
   logic            expire_s;
   logic            finish_s;

   assign any_req_s = req0_valid | req1_valid;
   // Completion is suppressed during reset so an abandoned transaction never reports done.
   assign ack_s     = (state_r == BUSY) && mem_ack && !rst;
   assign expire_s  = (state_r == BUSY) && (cnt_r == LAST_CNT) && !rst;
   assign finish_s  = ack_s | expire_s;
   assign req_rdata = mem_rdata;

   // Round-robin winner selection among the currently valid requesters
   always_comb begin
      grant_s = REQ_FETCH;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_owner_r;
      end else if (req1_valid) begin
         grant_s = REQ_LSU;
      end else begin
         grant_s = REQ_FETCH;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) state_nxt_s = BUSY;
            else           state_nxt_s = IDLE;
         end
         BUSY: begin
            if (finish_s) state_nxt_s = IDLE;
            else          state_nxt_s = BUSY;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Ownership, round-robin history and watchdog counter
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r      <= REQ_FETCH;
         last_owner_r <= REQ_LSU;
         cnt_r        <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= {CW{1'b0}};
               if (any_req_s) owner_r <= grant_s;
               else           owner_r <= owner_r;
            end
            BUSY: begin
               cnt_r <= cnt_r + CW'(1);
               if (finish_s) last_owner_r <= owner_r;
               else          last_owner_r <= last_owner_r;
            end
            default: cnt_r <= {CW{1'b0}};
         endcase
      end
   end

   // Port and completion outputs decoded from the current state
   always_comb begin
      mem_valid = 1'b0;
      busy      = 1'b0;
      req0_done = 1'b0;
      req1_done = 1'b0;
      req0_err  = 1'b0;
      req1_err  = 1'b0;
      case (state_r)
         IDLE: begin
            mem_valid = 1'b0;
            busy      = 1'b0;
         end
         BUSY: begin
            mem_valid = 1'b1;
            busy      = 1'b1;
            req0_done = finish_s && (owner_r == REQ_FETCH);
            req1_done = finish_s && (owner_r == REQ_LSU);
            req0_err  = req0_done && !ack_s;
            req1_err  = req1_done && !ack_s;
         end
         default: begin
            mem_valid = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

   mux #(.WIDTH(AWIDTH)) u_addr_mux (
      .sel  (owner_r),
      .in0  (req0_addr),
      .in1  (req1_addr),
      .dout (mem_addr)
   );

   mux #(.WIDTH(WIDTH)) u_wdata_mux (
      .sel  (owner_r),
      .in0  (req0_wdata),
      .in1  (req1_wdata),
      .dout (mem_wdata)
   );

   mux #(.WIDTH(1)) u_we_mux (
      .sel  (owner_r),
      .in0  (req0_we),
      .in1  (req1_we),
      .dout (mem_we)
   );

endmodule
